// File: rtl/toggle_activity_counter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | toggle_activity_counter_if : window control and result bus           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface toggle_activity_counter_if #(
    parameter int CNT_W = 16
);
    logic               start;
    logic [15:0]        win_len;
    logic [3:0]         d;
    logic               res_ready;
    logic               busy;
    logic               res_valid;
    logic [CNT_W-1:0]   tog0;
    logic [CNT_W-1:0]   tog1;
    logic [CNT_W-1:0]   tog2;
    logic [CNT_W-1:0]   tog3;
    logic [CNT_W+1:0]   tog_total;

    modport master (
        output start, win_len, d, res_ready,
        input  busy, res_valid, tog0, tog1, tog2, tog3, tog_total
    );

    modport slave (
        input  start, win_len, d, res_ready,
        output busy, res_valid, tog0, tog1, tog2, tog3, tog_total
    );
endinterface
`default_nettype wire

// File: rtl/toggle_activity_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | toggle_activity_counter : saturating per-line toggle counts over a   |
// | window of win_len compared samples. Rev 1.0                          |
// +----------------------------------------------------------------------+
module toggle_activity_counter #(
    parameter int CNT_W = 16
) (
    input  wire logic                     clk,
    input  wire logic                     rst_n,
    toggle_activity_counter_if.slave      bus
);
    localparam int               TOT_W   = CNT_W + 2;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        COUNT = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        rem_q, rem_d;
    logic [3:0]         prev_q, prev_d;
    logic [CNT_W-1:0]   cnt_q [4];
    logic [CNT_W-1:0]   cnt_d [4];
    logic [TOT_W-1:0]   total_q, total_d;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        prev_d  = prev_q;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = cnt_q[i];
        end

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = PRIME;
                    rem_d   = bus.win_len;
                    for (int i = 0; i < 4; i++) begin
                        cnt_d[i] = '0;
                    end
                end
            end
            PRIME: begin
                prev_d  = bus.d;
                state_d = (rem_q != 16'd0) ? COUNT : HOLD;
            end
            COUNT: begin
                prev_d = bus.d;
                rem_d  = rem_q - 16'd1;
                for (int i = 0; i < 4; i++) begin
                    if ((bus.d[i] != prev_q[i]) && (cnt_q[i] != CNT_MAX)) begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                if (rem_q == 16'd1) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (bus.res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Total is rebuilt from the next counts so it can never drift from them.
        total_d = TOT_W'(cnt_d[0]) + TOT_W'(cnt_d[1])
                + TOT_W'(cnt_d[2]) + TOT_W'(cnt_d[3]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            prev_q  <= '0;
            total_q <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            prev_q  <= prev_d;
            total_q <= total_d;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign bus.busy      = (state_q == PRIME) || (state_q == COUNT);
    assign bus.res_valid = (state_q == HOLD);
    assign bus.tog0      = cnt_q[0];
    assign bus.tog1      = cnt_q[1];
    assign bus.tog2      = cnt_q[2];
    assign bus.tog3      = cnt_q[3];
    assign bus.tog_total = total_q;
endmodule
`default_nettype wire
